// File: rtl/io_bridge_pkg.sv
// io_bridge_pkg -- shared constants for the CPU <-> external I/O bridge.
//   * Default memory-mapped addresses for the input pop, output push and
//     status registers.
//   * Bit positions of the status word returned when the build defines
//     IO_BRIDGE_STATUS_EN.
//   * Helper that squeezes a FIFO count into the 4-bit status field.
package io_bridge_pkg;

    localparam logic [15:0] DEF_IN_ADDR   = 16'hFFF0;
    localparam logic [15:0] DEF_OUT_ADDR  = 16'hFFF1;
    localparam logic [15:0] DEF_STAT_ADDR = 16'hFFF2;

    // Status word layout: {8'b0, out_count[3:0], in_full, in_empty, out_full, out_empty}
    localparam int STAT_OUT_EMPTY_BIT = 0;
    localparam int STAT_OUT_FULL_BIT  = 1;
    localparam int STAT_IN_EMPTY_BIT  = 2;
    localparam int STAT_IN_FULL_BIT   = 3;
    localparam int STAT_COUNT_LSB     = 4;
    localparam int STAT_COUNT_W       = 4;

    // A DEPTH=16 FIFO can hold 16 words, which does not fit in four bits;
    // saturate at 15 so a full FIFO never reads back as empty.
    function automatic logic [STAT_COUNT_W-1:0] count_nibble(input logic [7:0] cnt);
        logic [STAT_COUNT_W-1:0] res;
        res = (cnt > 8'd15) ? 4'hF : cnt[3:0];
        return res;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo -- small synchronous FIFO with a combinational head output.
// Ports:
//   clock        rising-edge clock
//   rst          asynchronous active-low reset (clears pointers and count)
//   push, wdata  write request / data; ignored when full
//   pop          read request; ignored when empty
//   head         word at the read pointer (valid only when !empty)
//   full, empty  derived from the registered count
//   count        occupancy, 0..DEPTH
// Storage is not reset; only the bookkeeping is.
module io_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PW:0]      count_reg,  count_next;
    logic             push_en, pop_en;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_en) wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (pop_en)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem_reg[wr_ptr_reg] <= wdata;
    end

endmodule

// File: rtl/io_bridge.sv
// io_bridge -- memory-mapped bridge between a CPU memory stage and a pair of
// external streaming ports (valid/ready), buffered by two io_fifo instances.
// Ports:
//   clock, rst                 clock / asynchronous active-low reset
//   addr, wdata                memory-stage address and store data
//   memread, memwrite          load / store strobes (both high = store)
//   rdata                      load data back to the memory stage
//   io_stall                   pipeline stall request
//   in_data, in_valid, in_ready     external input stream
//   out_data, out_valid, out_ready  external output stream
// Loads from IN_ADDR pop the input FIFO, stores to OUT_ADDR push the output
// FIFO. Stall decisions use the registered counts only (no same-cycle bypass).
// Optional: define IO_BRIDGE_STATUS_EN to map a status word at STAT_ADDR.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] IN_ADDR   = DEF_IN_ADDR,
    parameter logic [15:0] OUT_ADDR  = DEF_OUT_ADDR,
    parameter logic [15:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        memread,
    input  logic        memwrite,
    output logic [15:0] rdata,
    output logic        io_stall,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   in_head, out_head;
    logic          in_full, in_empty, out_full, out_empty;
    logic [CW-1:0] in_count, out_count;
    logic          in_push, in_pop, out_push, out_pop;
    logic          store_out, load_in;

    // CPU decodes are gated by reset so nothing stalls or reads while rst is low.
    // A combined read+write strobe is a store, so loads require !memwrite.
    assign store_out = rst && memwrite && (addr == OUT_ADDR);
    assign load_in   = rst && memread && !memwrite && (addr == IN_ADDR);

    assign in_ready  = !in_full;
    assign in_push   = in_valid && !in_full;
    assign in_pop    = load_in && !in_empty;

    assign out_valid = !out_empty;
    // Storage survives reset, so mask stale head data while empty.
    assign out_data  = out_empty ? 16'h0000 : out_head;
    assign out_push  = store_out && !out_full;
    assign out_pop   = out_valid && out_ready;

    assign io_stall  = (load_in && in_empty) || (store_out && out_full);

`ifdef IO_BRIDGE_STATUS_EN
    logic        load_stat;
    logic [15:0] status_word;
    logic        count_unused;

    assign load_stat    = rst && memread && !memwrite && (addr == STAT_ADDR);
    assign count_unused = ^in_count;

    always_comb begin
        status_word = 16'h0000;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = count_nibble(8'(out_count));
        status_word[STAT_IN_FULL_BIT]   = in_full;
        status_word[STAT_IN_EMPTY_BIT]  = in_empty;
        status_word[STAT_OUT_FULL_BIT]  = out_full;
        status_word[STAT_OUT_EMPTY_BIT] = out_empty;
    end

    always_comb begin
        rdata = 16'h0000;
        if (in_pop)         rdata = in_head;
        else if (load_stat) rdata = status_word;
    end
`else
    logic count_unused;

    assign count_unused = ^{in_count, out_count};

    always_comb begin
        rdata = 16'h0000;
        if (in_pop) rdata = in_head;
    end
`endif

    io_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_in_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (in_data),
        .head  (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    io_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_out_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (out_push),
        .pop   (out_pop),
        .wdata (wdata),
        .head  (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

endmodule
